// File: rtl/store_unit.sv
// store_unit: CPU store path to data memory. Validates size/alignment, lane-shifts
// write data, builds byte strobes and holds one outstanding write until mem_ack
// or a TIMEOUT-cycle abort.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   st_valid/st_ready        CPU request handshake (ready only while idle)
//   st_addr/st_data/st_size  store byte address, right-justified data, width
//   mem_req/mem_addr/mem_wdata/mem_wstrb/mem_ack   memory write channel
//   st_done, st_err/err_code completion and error pulses
module store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  output logic        st_done,
  output logic        st_err,
  output logic [1:0]  err_code
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_SIZE     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic [31:0]      lane_wdata;
  logic [3:0]       lane_wstrb;
  logic [1:0]       req_code;

  // Request check and lane placement; illegal size wins over misalignment.
  always_comb begin
    lane_wdata = st_data;
    lane_wstrb = 4'b1111;
    req_code   = ERR_NONE;
    case (st_size)
      SZ_BYTE: begin
        lane_wdata = {4{st_data[7:0]}};
        lane_wstrb = 4'b0001 << st_addr[1:0];
      end
      SZ_HALF: begin
        lane_wdata = {2{st_data[15:0]}};
        lane_wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
        if (st_addr[0]) req_code = ERR_MISALIGN;
      end
      SZ_WORD: begin
        if (st_addr[1:0] != 2'b00) req_code = ERR_MISALIGN;
      end
      default: req_code = ERR_SIZE;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (st_valid) begin
          if (req_code != ERR_NONE) begin
            err_d  = 1'b1;
            code_d = req_code;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
            addr_d  = {st_addr[31:2], 2'b00};
            wdata_d = lane_wdata;
            wstrb_d = lane_wstrb;
          end
        end
      end
      WAIT: begin
        // Ack beats the timeout when both land in the same cycle.
        if (mem_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign st_ready  = (state_q == IDLE);
  assign mem_req   = (state_q == WAIT);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign st_done   = done_q;
  assign st_err    = err_q;
  assign err_code  = code_q;

endmodule
